// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: entry layout, data-path widths
// and the default ROB depth.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif

package reorder_buffer_pkg;

    localparam int XLEN = 32;

    // One ROB slot: valid flag plus the fields retire needs to commit.
    typedef struct packed {
        logic            valid;
        logic [4:0]      dest_idx;
        logic            has_dest;
        logic [XLEN-1:0] NPC;
    } ROB_ENTRY;

endpackage

// File: rtl/reorder_buffer_chk.sv
// Protocol checker: retire must not ask to free an entry from an empty ROB.
// The RTL ignores such a request; this only reports it in simulation.
module reorder_buffer_chk (
    input logic clock,
    input logic reset,
    input logic move_head,
    input logic empty
);

    // Flag move_head sampled while the buffer holds nothing.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(move_head && empty))
                else $warning("reorder_buffer: move_head asserted while empty, ignored");
        end
    end

endmodule

// File: rtl/reorder_buffer_ptr.sv
// Wrapping pointer for the reorder buffer: synchronous clear wins over
// increment, and the natural overflow of W bits gives the SZ-1 -> 0 roll.
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value: clear, advance, or hold.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = {W{1'b0}};
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= {W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: dispatch allocates at tail, retire frees at head.
// Occupancy is tracked by a separate count so head==tail is unambiguous.
import reorder_buffer_pkg::*;

module reorder_buffer #(
    parameter int SZ = `ROB_SZ
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dispatch_valid,
    input  logic [4:0]             dispatch_dest_idx,
    input  logic                   dispatch_has_dest,
    input  logic [XLEN-1:0]        dispatch_NPC,
    output logic                   dispatch_ready,
    output logic [$clog2(SZ)-1:0]  dispatch_rob_index,
    input  logic                   move_head,
    input  logic                   clear,
    output logic [$clog2(SZ)-1:0]  rob_head,
    output logic                   head_valid,
    output logic [4:0]             head_dest_idx,
    output logic                   head_has_dest,
    output logic [XLEN-1:0]        head_NPC,
    output logic [$clog2(SZ):0]    rob_count,
    output logic                   full,
    output logic                   empty
);

    localparam int IW = $clog2(SZ);
    localparam int CW = IW + 1;

    logic [IW-1:0] head_s;
    logic [IW-1:0] tail_s;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    ROB_ENTRY      entry_q [SZ];
    ROB_ENTRY      entry_d [SZ];
    logic          alloc_s;
    logic          free_s;

    // Status derives from the registered count only, never from this cycle's inputs.
    assign full    = (count_q == CW'(SZ));
    assign empty   = (count_q == {CW{1'b0}});
    assign alloc_s = dispatch_valid && !full;
    assign free_s  = move_head && !empty;

    rob_ptr #(.W(IW)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (free_s),
        .ptr   (head_s)
    );

    rob_ptr #(.W(IW)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (alloc_s),
        .ptr   (tail_s)
    );

    // Occupancy update: +alloc -free, flush empties the buffer.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (alloc_s && !free_s) begin
            count_d = count_q + CW'(1);
        end else if (free_s && !alloc_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Entry array update: write at tail on alloc, drop valid at head on free.
    // Alloc and free never target the same slot since alloc needs !full.
    always_comb begin
        for (int i = 0; i < SZ; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (clear) begin
            for (int i = 0; i < SZ; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else begin
            if (free_s) begin
                entry_d[head_s].valid = 1'b0;
            end else begin
                entry_d[head_s].valid = entry_q[head_s].valid;
            end
            if (alloc_s) begin
                entry_d[tail_s] = '{valid:    1'b1,
                                    dest_idx: dispatch_dest_idx,
                                    has_dest: dispatch_has_dest,
                                    NPC:      dispatch_NPC};
            end else begin
                entry_d[tail_s] = entry_d[tail_s];
            end
        end
    end

    // Count and entry registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
            for (int i = 0; i < SZ; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < SZ; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign dispatch_ready     = !full;
    assign dispatch_rob_index = tail_s;
    assign rob_head           = head_s;
    assign rob_count          = count_q;
    assign head_valid         = entry_q[head_s].valid;
    assign head_dest_idx      = entry_q[head_s].dest_idx;
    assign head_has_dest      = entry_q[head_s].has_dest;
    assign head_NPC           = entry_q[head_s].NPC;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
import reorder_buffer_pkg::*;

module tb_reorder_buffer;

    localparam int SZ = 8;
    localparam int IW = $clog2(SZ);

    logic            clock;
    logic            reset;
    logic            dispatch_valid;
    logic [4:0]      dispatch_dest_idx;
    logic            dispatch_has_dest;
    logic [XLEN-1:0] dispatch_NPC;
    logic            dispatch_ready;
    logic [IW-1:0]   dispatch_rob_index;
    logic            move_head;
    logic            clear;
    logic [IW-1:0]   rob_head;
    logic            head_valid;
    logic [4:0]      head_dest_idx;
    logic            head_has_dest;
    logic [XLEN-1:0] head_NPC;
    logic [IW:0]     rob_count;
    logic            full;
    logic            empty;

    reorder_buffer #(.SZ(SZ)) dut (
        .clock              (clock),
        .reset              (reset),
        .dispatch_valid     (dispatch_valid),
        .dispatch_dest_idx  (dispatch_dest_idx),
        .dispatch_has_dest  (dispatch_has_dest),
        .dispatch_NPC       (dispatch_NPC),
        .dispatch_ready     (dispatch_ready),
        .dispatch_rob_index (dispatch_rob_index),
        .move_head          (move_head),
        .clear              (clear),
        .rob_head           (rob_head),
        .head_valid         (head_valid),
        .head_dest_idx      (head_dest_idx),
        .head_has_dest      (head_has_dest),
        .head_NPC           (head_NPC),
        .rob_count          (rob_count),
        .full               (full),
        .empty              (empty)
    );

    reorder_buffer_chk u_chk (
        .clock     (clock),
        .reset     (reset),
        .move_head (move_head),
        .empty     (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a FIFO of in-flight instructions plus plain-integer indices.
    typedef struct {
        logic [4:0]      dest;
        logic            hd;
        logic [XLEN-1:0] npc;
    } inst_t;

    inst_t m_q[$];
    int    m_head;
    int    m_tail;
    int    n_checks;
    int    n_fail;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output to the model's current state.
    task automatic check_outputs();
        check_val("rob_count", 64'(rob_count), 64'(m_q.size()));
        check_val("empty", 64'(empty), 64'(m_q.size() == 0));
        check_val("full", 64'(full), 64'(m_q.size() == SZ));
        check_val("dispatch_ready", 64'(dispatch_ready), 64'(m_q.size() != SZ));
        check_val("rob_head", 64'(rob_head), 64'(m_head));
        check_val("dispatch_rob_index", 64'(dispatch_rob_index), 64'(m_tail));
        check_val("head_valid", 64'(head_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("head_dest_idx", 64'(head_dest_idx), 64'(m_q[0].dest));
            check_val("head_has_dest", 64'(head_has_dest), 64'(m_q[0].hd));
            check_val("head_NPC", 64'(head_NPC), 64'(m_q[0].npc));
        end
    endtask

    // One clock: drive inputs, check pre-edge state at negedge, advance model at posedge.
    task automatic cycle(input logic dv, input logic [4:0] dest, input logic hd,
                         input logic [XLEN-1:0] npc, input logic mh, input logic clr);
        bit    do_alloc;
        bit    do_free;
        inst_t it;
        dispatch_valid    = dv;
        dispatch_dest_idx = dest;
        dispatch_has_dest = hd;
        dispatch_NPC      = npc;
        move_head         = mh;
        clear             = clr;
        @(negedge clock);
        check_outputs();
        if (clr) begin
            m_q.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            do_alloc = dv && (m_q.size() < SZ);
            do_free  = mh && (m_q.size() > 0);
            if (do_free) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % SZ;
            end
            if (do_alloc) begin
                it.dest = dest;
                it.hd   = hd;
                it.npc  = npc;
                m_q.push_back(it);
                m_tail = (m_tail + 1) % SZ;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic disp(input logic [4:0] dest, input logic [XLEN-1:0] npc, input logic mh);
        cycle(1'b1, dest, dest[0], npc, mh, 1'b0);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        m_head            = 0;
        m_tail            = 0;
        reset             = 1'b1;
        dispatch_valid    = 1'b0;
        dispatch_dest_idx = 5'd0;
        dispatch_has_dest = 1'b0;
        dispatch_NPC      = 32'd0;
        move_head         = 1'b0;
        clear             = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state held across idle cycles.
        repeat (3) idle();

        // Fill: eight back-to-back allocations, then a refused ninth.
        for (int i = 0; i < SZ; i++) begin
            disp(5'(i + 1), 32'(4 * (i + 1)), 1'b0);
        end
        disp(5'd20, 32'h100, 1'b0);
        check_val("full_head_npc", 64'(head_NPC), 64'h4);

        // Full with free + dispatch: free happens, alloc refused; then wrap alloc.
        disp(5'd21, 32'h104, 1'b1);
        check_val("after_free_head", 64'(rob_head), 64'd1);
        check_val("after_free_count", 64'(rob_count), 64'd7);
        disp(5'd22, 32'h108, 1'b0);
        check_val("wrap_count", 64'(rob_count), 64'd8);

        // Drain to count 3, then 20 cycles of alloc+free in lockstep.
        repeat (5) cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            disp(5'($urandom_range(0, 31)), 32'h200 + 32'(4 * i), 1'b1);
        end
        check_val("steady_count", 64'(rob_count), 64'd3);

        // Grow to 5, then flush together with dispatch and free.
        disp(5'd9, 32'h300, 1'b0);
        disp(5'd10, 32'h304, 1'b0);
        cycle(1'b1, 5'd11, 1'b1, 32'h308, 1'b1, 1'b1);
        idle();

        // Empty: lone free is ignored; free with dispatch allocates only.
        cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        disp(5'd12, 32'h400, 1'b1);
        idle();

        // Random traffic; free mostly only when the model holds something.
        for (int i = 0; i < 400; i++) begin
            logic dv;
            logic mh;
            logic clr;
            dv  = ($urandom_range(0, 99) < 60);
            mh  = (m_q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 2);
            cycle(dv, 5'($urandom), 1'($urandom), $urandom, mh, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer that allocates entries to dispatching instructions at its tail and frees them at its head when the retire stage raises `move_head`. It supplies the ROB index that travels with each instruction to the complete stage and onward in `CO_RE_PACKET.rob_index`. It also drives `rob_head`, which retire uses to pick the next instruction to commit. Sits between dispatch (producer) and retire (consumer of `rob_head`, producer of `move_head`).

## Interface
- `SZ`, default `` `ROB_SZ ``, number of entries; power of two, ≥2.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `dispatch_valid`  in  1  dispatch requests one allocation this cycle.
- `dispatch_dest_idx`  in  5  architectural destination register.
- `dispatch_has_dest`  in  1  instruction writes a register.
- `dispatch_NPC`  in  `XLEN`  next PC of the instruction.
- `dispatch_ready`  out  1  = !full; allocation accepted iff `dispatch_valid && dispatch_ready`.
- `dispatch_rob_index`  out  $clog2(SZ)  index assigned to an accepted allocation (= tail).
- `move_head`  in  1  retire committed entry at `rob_head`; free it.
- `clear`  in  1  flush (mispredict); same signal that clears the retire buffer.
- `rob_head`  out  $clog2(SZ)  current head index.
- `head_valid`, `head_dest_idx`, `head_has_dest`, `head_NPC`  out  1/5/1/`XLEN`  contents of entry at head.
- `rob_count`  out  $clog2(SZ)+1  occupied entries.
- `full`, `empty`  out  1  `rob_count==SZ`, `rob_count==0`.

## Operation
- State: `head`, `tail` (wrapping, $clog2(SZ) bits), `count` ($clog2(SZ)+1 bits), entry array of `ROB_ENTRY` {valid, dest_idx, has_dest, NPC}.
- alloc = `dispatch_valid && !full`; full/empty come from registered `count` only. There is no same-cycle bypass from `move_head`.
- alloc: `entry[tail]` ← {1, dispatch fields}; `tail` ← tail+1 mod SZ.
- free = `move_head && !empty`: `entry[head].valid` ← 0; `head` ← head+1 mod SZ.
- `move_head` while empty: ignored, no state change; simulation assertion fires.
- `count` ← count + alloc − free. Simultaneous alloc+free leaves count unchanged.
- Wrap-around: pointers roll SZ−1 → 0 with no special case. head==tail is disambiguated solely by `count`.
- `clear` (or `reset`): head ← 0, tail ← 0, count ← 0, all entry valid bits ← 0. Takes priority over any alloc/free in the same cycle. The dispatch request in that cycle is dropped even though `dispatch_ready` may read 1.
- Indices restart at 0 after a flush, matching the cleared retire buffer.

## Timing
- Reset values: `rob_head`=0, `dispatch_rob_index`=0, `rob_count`=0, `empty`=1, `full`=0, `dispatch_ready`=1, `head_valid`=0. `head_dest_idx`/`head_has_dest`/`head_NPC` are don't-care while `head_valid`=0.
- `dispatch_ready`, `dispatch_rob_index`, `rob_head`, `full`, `empty`, `rob_count` are combinational from registers only. There are no input→output combinational paths.
- `head_*` outputs are a combinational read of `entry[head]`.
- Allocation latency: entry becomes visible at head (if ROB was empty) the cycle after acceptance.
- Free latency: `rob_head` advances the cycle after `move_head` is sampled. Retire may therefore assert `move_head` at most once per cycle, for the head it sees that cycle.
- Full + `move_head` + `dispatch_valid` in the same cycle: free occurs, alloc refused. `dispatch_ready`=1 the next cycle.
- Empty + `dispatch_valid` + `move_head` in the same cycle: alloc occurs, `move_head` ignored.
- Throughput: 1 alloc + 1 free per cycle.

## Structure
- `ROB_ENTRY` typedef goes in the shared `sys_defs` package, alongside `CO_RE_PACKET`/`RETIRE_ENTRY`. `ROB_SZ` stays the shared macro.
- One sub-module is natural: `rob_ptr`, a wrapping $clog2(SZ)-bit counter with synchronous clear and increment enable. Instantiate it twice, once for head and once for tail.
- Count logic and entry array stay in `reorder_buffer`.

## Test plan
- Reset, then idle 3 cycles → `rob_head`=0, `dispatch_rob_index`=0, `rob_count`=0, `empty`=1, `dispatch_ready`=1.
- SZ=8: dispatch 8 back-to-back (NPC 0x4,0x8,…,0x20) → indices 0..7 returned, `full`=1 after 8th, 9th `dispatch_valid` refused, `head_NPC`=0x4.
- Full, assert `move_head`+`dispatch_valid` together → alloc refused, `rob_head`=1, `rob_count`=7. Next cycle alloc succeeds at index 0 (wrap), `rob_count`=8.
- Steady state, alloc+free every cycle for 20 cycles starting at count=3 → `rob_count` stays 3, head and tail wrap 7→0 correctly, `head_dest_idx` matches dispatch order.
- Count=5, `clear` together with `dispatch_valid` and `move_head` → next cycle head=tail=0, count=0, `head_valid`=0, dispatched instruction not stored.
- Empty, `move_head`=1 alone → no state change, assertion reported. Empty + dispatch + `move_head` → `rob_count`=1, `rob_head`=0.
